// File: rtl/isa_bus_master.sv
// isa_bus_master: 8-bit ISA memory/IO cycle initiator.
// Sequences address setup, strobe, ready wait and hold for one request.
module isa_bus_master #(
    parameter int unsigned ADDR_SETUP  = 1,
    parameter int unsigned STROBE_MIN  = 4,
    parameter int unsigned HOLD        = 1,
    parameter int unsigned RDY_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [1:0]  req_type,
    input  logic [19:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [7:0]  rdata,
    output logic [19:0] bus_a,
    output logic        bus_memr_l,
    output logic        bus_memw_l,
    output logic        bus_ior_l,
    output logic        bus_iow_l,
    output logic [7:0]  bus_d_out,
    output logic        bus_d_oe,
    input  logic [7:0]  bus_d_in,
    output logic        bus_aen,
    input  logic        bus_rdy
);

    localparam logic [7:0] SETUP_N =
        (ADDR_SETUP == 0) ? 8'd1 : 8'(ADDR_SETUP);
    localparam logic [7:0] STRB_N =
        (STROBE_MIN == 0) ? 8'd1 : 8'(STROBE_MIN);
    localparam logic [7:0] HOLD_N =
        (HOLD == 0) ? 8'd1 : 8'(HOLD);
    localparam logic [7:0] TMO_N =
        (RDY_TIMEOUT == 0) ? 8'd1 : 8'(RDY_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_WAIT_RDY,
        ST_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  typ_q, typ_d;
    logic        abort_q, abort_d;
    logic [19:0] addr_q, addr_d;
    logic [3:0]  strb_q, strb_d;
    logic [7:0]  dout_q, dout_d;
    logic        oe_q, oe_d;
    logic        aen_q, aen_d;
    logic        busy_q, busy_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        finish;
    logic        timeout;
    logic [3:0]  strb_sel;

    // State and all registered outputs; reset clears the bus at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            typ_q   <= 2'd0;
            abort_q <= 1'b0;
            addr_q  <= 20'd0;
            strb_q  <= 4'hF;
            dout_q  <= 8'd0;
            oe_q    <= 1'b0;
            aen_q   <= 1'b1;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            typ_q   <= typ_d;
            abort_q <= abort_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            aen_q   <= aen_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state and next-output computation for the cycle sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        typ_d    = typ_q;
        abort_d  = abort_q;
        addr_d   = addr_q;
        strb_d   = strb_q;
        dout_d   = dout_q;
        oe_d     = oe_q;
        aen_d    = aen_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        finish   = 1'b0;
        timeout  = 1'b0;
        strb_sel = ~(4'b0001 << typ_q);

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_SETUP;
                    cnt_d   = 8'd1;
                    typ_d   = req_type;
                    abort_d = 1'b0;
                    addr_d  = req_type[1] ?
                              {4'h0, req_addr[15:0]} : req_addr;
                    aen_d   = 1'b0;
                    oe_d    = req_type[0];
                    if (req_type[0]) begin
                        dout_d = req_wdata;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q >= SETUP_N) begin
                    state_d = ST_STROBE;
                    cnt_d   = 8'd1;
                    strb_d  = strb_sel;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q >= STRB_N) begin
                    if (bus_rdy) begin
                        finish = 1'b1;
                    end else begin
                        state_d = ST_WAIT_RDY;
                        cnt_d   = 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WAIT_RDY: begin
                if (bus_rdy) begin
                    finish = 1'b1;
                end else if (cnt_q >= TMO_N) begin
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q >= HOLD_N) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                    ack_d   = 1'b1;
                    err_d   = abort_q;
                    aen_d   = 1'b1;
                    oe_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (finish || timeout) begin
            state_d = ST_HOLD;
            cnt_d   = 8'd1;
            strb_d  = 4'hF;
            abort_d = timeout;
            if (!typ_q[0]) begin
                rdata_d = timeout ? 8'hFF : bus_d_in;
            end
        end
    end

    assign busy_d = (state_d != ST_IDLE);

    assign busy       = busy_q;
    assign ack        = ack_q;
    assign err        = err_q;
    assign rdata      = rdata_q;
    assign bus_a      = addr_q;
    assign bus_memr_l = strb_q[0];
    assign bus_memw_l = strb_q[1];
    assign bus_ior_l  = strb_q[2];
    assign bus_iow_l  = strb_q[3];
    assign bus_d_out  = dout_q;
    assign bus_d_oe   = oe_q;
    assign bus_aen    = aen_q;

endmodule

// File: tb/tb_isa_bus_master.sv
// tb_isa_bus_master: directed and randomized checks of isa_bus_master.
// Expected cycle timing comes from the setup/strobe/wait/hold cycle formula.
module tb_isa_bus_master;

    localparam int S = 1;
    localparam int W = 4;
    localparam int H = 1;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [1:0]  req_type;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        busy, ack, err;
    logic [7:0]  rdata;
    logic [19:0] bus_a;
    logic        bus_memr_l, bus_memw_l, bus_ior_l, bus_iow_l;
    logic [7:0]  bus_d_out;
    logic        bus_d_oe;
    logic [7:0]  bus_d_in;
    logic        bus_aen;
    logic        bus_rdy;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_rdata;

    isa_bus_master #(
        .ADDR_SETUP(S), .STROBE_MIN(W), .HOLD(H), .RDY_TIMEOUT(T)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_type(req_type),
        .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy),
        .ack(ack), .err(err), .rdata(rdata), .bus_a(bus_a),
        .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l),
        .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l),
        .bus_d_out(bus_d_out), .bus_d_oe(bus_d_oe),
        .bus_d_in(bus_d_in), .bus_aen(bus_aen), .bus_rdy(bus_rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] strobes();
        return {bus_iow_l, bus_ior_l, bus_memw_l, bus_memr_l};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ack", 32'(ack), 32'd0);
        chk("idle_strb", 32'(strobes()), 32'hF);
        chk("idle_aen", 32'(bus_aen), 32'd1);
        chk("idle_oe", 32'(bus_d_oe), 32'd0);
        chk("idle_rdata", 32'(rdata), 32'(exp_rdata));
    endtask

    // One transaction started from an idle cycle; k extra not-ready cycles.
    task automatic run_txn(input logic [1:0] ty, input logic [19:0] ad,
                           input logic [7:0] wd, input int k,
                           input bit stuck, input bit pulse);
        int low_end;
        int ackc;
        logic [19:0] ea;
        logic [3:0] es;
        logic [7:0] din;
        low_end = S + W + (stuck ? T : k);
        ackc = low_end + H + 1;
        ea = ty[1] ? {4'h0, ad[15:0]} : ad;
        req = 1'b1;
        req_type = ty;
        req_addr = ad;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req = 1'b0;
        for (int c = 1; c <= ackc; c++) begin
            din = 8'($urandom);
            bus_d_in = din;
            if (c < S + W || c > low_end)
                bus_rdy = 1'($urandom);
            else
                bus_rdy = !stuck && (c == low_end);
            if (pulse && c == 2) begin
                req = 1'b1;
                req_type = ~ty;
                req_addr = 20'($urandom);
            end else begin
                req = 1'b0;
            end
            es = 4'hF;
            if (c > S && c <= low_end) es[ty] = 1'b0;
            chk("strobe", 32'(strobes()), 32'(es));
            chk("busy", 32'(busy), 32'(c < ackc));
            chk("ack", 32'(ack), 32'(c == ackc));
            chk("aen", 32'(bus_aen), 32'(c == ackc));
            chk("d_oe", 32'(bus_d_oe), 32'(ty[0] && c < ackc));
            if (c < ackc) chk("bus_a", 32'(bus_a), 32'(ea));
            if (ty[0] && c < ackc)
                chk("d_out", 32'(bus_d_out), 32'(wd));
            if (c == ackc) begin
                chk("err", 32'(err), 32'(stuck));
                chk("rdata", 32'(rdata), 32'(exp_rdata));
            end
            if (c == low_end && !ty[0])
                exp_rdata = stuck ? 8'hFF : din;
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        bus_rdy = 1'b0;
        idle_chk();
    endtask

    logic [1:0] bb_ty [3];

    initial begin
        reset = 1'b1;
        req = 1'b0;
        req_type = 2'd0;
        req_addr = 20'd0;
        req_wdata = 8'd0;
        bus_d_in = 8'd0;
        bus_rdy = 1'b0;
        exp_rdata = 8'd0;
        #2;
        chk("rst_strb", 32'(strobes()), 32'hF);
        chk("rst_aen", 32'(bus_aen), 32'd1);
        chk("rst_a", 32'(bus_a), 32'd0);
        chk("rst_dout", 32'(bus_d_out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        idle_chk();
        #10;
        reset = 1'b0;
        @(posedge clk);
        #1;
        idle_chk();

        // memw, ready immediately
        run_txn(2'b01, 20'hB8000, 8'hA5, 0, 1'b0, 1'b0);
        // memr with three wait states
        run_txn(2'b00, 20'hB8123, 8'h00, 3, 1'b0, 1'b0);
        // ior: upper address nibble forced to zero
        run_txn(2'b10, 20'hFF3DA, 8'h00, 0, 1'b0, 1'b0);
        // memr, ready never arrives
        run_txn(2'b00, 20'h12345, 8'h00, 0, 1'b1, 1'b0);
        // memw timeout keeps rdata
        run_txn(2'b01, 20'h00010, 8'h77, 0, 1'b1, 1'b1);

        // reset in the middle of an iow strobe
        req = 1'b1;
        req_type = 2'b11;
        req_addr = 20'h003F8;
        req_wdata = 8'h5C;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_rst_iow", 32'(bus_iow_l), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        exp_rdata = 8'd0;
        chk("rst_iow", 32'(bus_iow_l), 32'd1);
        chk("rst_oe", 32'(bus_d_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_aen2", 32'(bus_aen), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("rst_no_ack", 32'(ack), 32'd0);
        end
        run_txn(2'b11, 20'h003F8, 8'h5C, 1, 1'b0, 1'b0);

        // req held high, alternating memw/memr
        bb_ty[0] = 2'b01;
        bb_ty[1] = 2'b00;
        bb_ty[2] = 2'b01;
        bus_rdy = 1'b1;
        bus_d_in = 8'h5A;
        req = 1'b1;
        req_type = bb_ty[0];
        req_addr = 20'hA0000;
        req_wdata = 8'h11;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 21; c++) begin
            int p;
            int idx;
            logic [3:0] es;
            p = ((c - 1) % 7) + 1;
            idx = (c - 1) / 7;
            if (c == 1) req_type = bb_ty[1];
            if (c == 8) req_type = bb_ty[2];
            if (c == 15) req = 1'b0;
            es = 4'hF;
            if (p >= 2 && p <= 5) es[bb_ty[idx]] = 1'b0;
            chk("bb_strobe", 32'(strobes()), 32'(es));
            chk("bb_ack", 32'(ack), 32'(p == 7));
            chk("bb_busy", 32'(busy), 32'(p != 7));
            if (p == 5 && !bb_ty[idx][0]) exp_rdata = 8'h5A;
            if (p == 7) chk("bb_rdata", 32'(rdata), 32'(exp_rdata));
            @(posedge clk);
            #1;
        end
        bus_rdy = 1'b0;
        idle_chk();

        // randomized transactions
        for (int n = 0; n < 24; n++) begin
            run_txn(2'($urandom), 20'($urandom), 8'($urandom),
                    int'($urandom_range(0, 6)),
                    $urandom_range(0, 7) == 0,
                    1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
